// File: rtl/flash_op_seq.sv
// Flash operation sequencer: stages command/address/payload bytes into the
// serializer FIFO, then drives the SPI transaction controller, with WREN and WIP polling.
module flash_op_seq #(
    parameter int unsigned SSIZE    = 1,
    parameter logic [15:0] POLL_MAX = 16'hFFFF
) (
    input  logic        wr_clk,
    input  logic        wr_rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [1:0]  op_code,
    input  logic [23:0] op_addr,
    input  logic [8:0]  op_len,
    input  logic [7:0]  wd_data,
    input  logic        wd_vld,
    output logic        wd_rdy,
    output logic [7:0]  tx_data,
    output logic        tx_vld,
    input  logic        tx_rdy,
    input  logic [7:0]  rx_data,
    input  logic        rx_vld,
    output logic        request,
    output logic [2:0]  req_cmd,
    output logic [23:0] req_len,
    output logic [23:0] req_wr_len,
    input  logic        busy,
    input  logic        finish,
    output logic [7:0]  status_byte,
    output logic        op_done,
    output logic        op_err
);

    localparam int unsigned SH = (SSIZE == 4) ? 2 : (SSIZE == 2) ? 1 : 0;

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_PP   = 2'b01;
    localparam logic [1:0] OP_SE   = 2'b10;
    localparam logic [1:0] OP_RDSR = 2'b11;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b010;

    typedef enum logic [3:0] {
        S_IDLE, S_WREN_LOAD, S_WREN_REQ, S_WREN_WAIT, S_HDR_LOAD, S_PAYLOAD,
        S_MAIN_REQ, S_MAIN_WAIT, S_POLL_LOAD, S_POLL_REQ, S_POLL_WAIT, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  code_q, code_d;
    logic [23:0] addr_q, addr_d;
    logic [8:0]  len_q, len_d;
    logic [1:0]  idx_q, idx_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [15:0] poll_q, poll_d;
    logic        tx_vld_q, tx_vld_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        op_ready_q, op_ready_d;
    logic        request_q, request_d;
    logic [2:0]  req_cmd_q, req_cmd_d;
    logic [23:0] req_len_q, req_len_d;
    logic [23:0] req_wr_len_q, req_wr_len_d;
    logic [7:0]  status_q, status_d;
    logic        op_done_q, op_done_d;
    logic        op_err_q, op_err_d;
    logic [7:0]  rx_st;
    logic [1:0]  hdr_last;

    // Byte count to SCK cycles on the configured lane width.
    function automatic logic [23:0] sck(input logic [9:0] nbytes);
        return 24'({nbytes, 3'b000} >> SH);
    endfunction

    function automatic logic [7:0] hdr_byte(input logic [1:0] code, input logic [23:0] addr,
                                            input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd1:    b = addr[23:16];
            2'd2:    b = addr[15:8];
            2'd3:    b = addr[7:0];
            default: begin
                case (code)
                    OP_READ: b = 8'h03;
                    OP_PP:   b = 8'h02;
                    OP_SE:   b = 8'h20;
                    default: b = 8'h05;
                endcase
            end
        endcase
        return b;
    endfunction

    // Status seen this cycle: a byte arriving alongside finish must still count.
    assign rx_st    = rx_vld ? rx_data : status_q;
    assign hdr_last = (code_q == OP_RDSR) ? 2'd0 : 2'd3;

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        addr_d       = addr_q;
        len_d        = len_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        poll_d       = poll_q;
        tx_vld_d     = tx_vld_q;
        tx_data_d    = tx_data_q;
        request_d    = 1'b0;
        req_cmd_d    = req_cmd_q;
        req_len_d    = req_len_q;
        req_wr_len_d = req_wr_len_q;
        status_d     = status_q;
        op_done_d    = 1'b0;
        op_err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (op_valid && op_ready_q) begin
                    code_d  = op_code;
                    addr_d  = op_addr;
                    len_d   = (op_len == 9'd0) ? 9'd256 : op_len;
                    idx_d   = 2'd0;
                    cnt_d   = 9'd0;
                    poll_d  = 16'd0;
                    state_d = (op_code == OP_PP || op_code == OP_SE) ? S_WREN_LOAD : S_HDR_LOAD;
                end
            end
            S_WREN_LOAD: begin
                if (!tx_vld_q) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = 8'h06;
                end else if (tx_rdy) begin
                    tx_vld_d = 1'b0;
                    state_d  = S_WREN_REQ;
                end
            end
            S_WREN_REQ: begin
                if (!busy) begin
                    request_d    = 1'b1;
                    req_cmd_d    = CMD_WR;
                    req_len_d    = sck(10'd1);
                    req_wr_len_d = sck(10'd1);
                    state_d      = S_WREN_WAIT;
                end
            end
            S_WREN_WAIT: begin
                if (finish) state_d = S_HDR_LOAD;
            end
            S_HDR_LOAD: begin
                if (!tx_vld_q) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = hdr_byte(code_q, addr_q, idx_q);
                end else if (tx_rdy) begin
                    if (idx_q == hdr_last) begin
                        tx_vld_d = 1'b0;
                        state_d  = (code_q == OP_PP) ? S_PAYLOAD : S_MAIN_REQ;
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        tx_data_d = hdr_byte(code_q, addr_q, idx_q + 2'd1);
                    end
                end
            end
            S_PAYLOAD: begin
                if (wd_vld && tx_rdy) begin
                    cnt_d = cnt_q + 9'd1;
                    if (cnt_q == len_q - 9'd1) state_d = S_MAIN_REQ;
                end
            end
            S_MAIN_REQ: begin
                if (!busy) begin
                    request_d = 1'b1;
                    state_d   = S_MAIN_WAIT;
                    case (code_q)
                        OP_READ: begin
                            req_cmd_d    = CMD_RD;
                            req_wr_len_d = sck(10'd4);
                            req_len_d    = sck(10'(len_q) + 10'd4);
                        end
                        OP_PP: begin
                            req_cmd_d    = CMD_WR;
                            req_wr_len_d = sck(10'(len_q) + 10'd4);
                            req_len_d    = sck(10'(len_q) + 10'd4);
                        end
                        OP_SE: begin
                            req_cmd_d    = CMD_WR;
                            req_wr_len_d = sck(10'd4);
                            req_len_d    = sck(10'd4);
                        end
                        default: begin
                            req_cmd_d    = CMD_RD;
                            req_wr_len_d = sck(10'd1);
                            req_len_d    = sck(10'd2);
                        end
                    endcase
                end
            end
            S_MAIN_WAIT: begin
                if (rx_vld && code_q == OP_RDSR) status_d = rx_data;
                if (finish) begin
                    if (code_q == OP_READ || code_q == OP_RDSR) begin
                        op_done_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_POLL_LOAD;
                    end
                end
            end
            S_POLL_LOAD: begin
                if (!tx_vld_q) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = 8'h05;
                end else if (tx_rdy) begin
                    tx_vld_d = 1'b0;
                    state_d  = S_POLL_REQ;
                end
            end
            S_POLL_REQ: begin
                if (!busy) begin
                    request_d    = 1'b1;
                    req_cmd_d    = CMD_RD;
                    req_wr_len_d = sck(10'd1);
                    req_len_d    = sck(10'd2);
                    state_d      = S_POLL_WAIT;
                end
            end
            S_POLL_WAIT: begin
                status_d = rx_st;
                if (finish) begin
                    if (!rx_st[0]) begin
                        op_done_d = 1'b1;
                        state_d   = S_DONE;
                    end else if (poll_q == 16'(POLL_MAX - 16'd1)) begin
                        op_done_d = 1'b1;
                        op_err_d  = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        poll_d  = poll_q + 16'd1;
                        state_d = S_POLL_LOAD;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        op_ready_d = (state_d == S_IDLE) && !busy;
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q      <= S_IDLE;
            code_q       <= 2'd0;
            addr_q       <= 24'd0;
            len_q        <= 9'd0;
            idx_q        <= 2'd0;
            cnt_q        <= 9'd0;
            poll_q       <= 16'd0;
            tx_vld_q     <= 1'b0;
            tx_data_q    <= 8'd0;
            op_ready_q   <= 1'b0;
            request_q    <= 1'b0;
            req_cmd_q    <= 3'd0;
            req_len_q    <= 24'd0;
            req_wr_len_q <= 24'd0;
            status_q     <= 8'd0;
            op_done_q    <= 1'b0;
            op_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            poll_q       <= poll_d;
            tx_vld_q     <= tx_vld_d;
            tx_data_q    <= tx_data_d;
            op_ready_q   <= op_ready_d;
            request_q    <= request_d;
            req_cmd_q    <= req_cmd_d;
            req_len_q    <= req_len_d;
            req_wr_len_q <= req_wr_len_d;
            status_q     <= status_d;
            op_done_q    <= op_done_d;
            op_err_q     <= op_err_d;
        end
    end

    // Payload bytes stream straight through from the write-data port.
    assign tx_vld      = (state_q == S_PAYLOAD) ? wd_vld  : tx_vld_q;
    assign tx_data     = (state_q == S_PAYLOAD) ? wd_data : tx_data_q;
    assign wd_rdy      = (state_q == S_PAYLOAD) && tx_rdy;
    assign op_ready    = op_ready_q;
    assign request     = request_q;
    assign req_cmd     = req_cmd_q;
    assign req_len     = req_len_q;
    assign req_wr_len  = req_wr_len_q;
    assign status_byte = status_q;
    assign op_done     = op_done_q;
    assign op_err      = op_err_q;

endmodule
